// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

    // Default PC width; matches the 9-bit branch address.
    localparam int DEFAULT_PC_W = 9;

    // Width of the taken-branch statistics counter.
    localparam int STATS_W = 16;

endpackage

// File: rtl/fetch_sequencer_watchdog_counter.sv
// Runaway watchdog: counts enabled cycles and flags the last allowed one.
// The counter is held at zero while clear is asserted.
module watchdog_counter #(
    parameter int limit = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (limit > 1) ? $clog2(limit) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(limit - 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles; park at the last value (the sequencer leaves RUN there).
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller: owns the PC, run/halt state, commit strobe
// and a runaway watchdog.
// Optional feature macro: FETCH_SEQ_BRANCH_STATS_EN enables the taken-branch
// counter; when undefined taken_count is tied to zero.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              PC_W           = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] START_ADDR     = '0,
    parameter int              TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               imem_valid,
    input  logic               halt_instr,
    input  logic               branch,
    input  logic [PC_W-1:0]    branch_address,
    output logic [PC_W-1:0]    pc,
    output logic               instr_commit,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [STATS_W-1:0] taken_count
);

    seq_state_t state;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expire;
    logic       halt_commit;

    // running is a registered copy of (state == RUN), so commit is glitch-free w.r.t. state.
    assign instr_commit = running && imem_valid;
    assign halt_commit  = instr_commit && halt_instr;

    // Watchdog only counts RUN cycles and restarts from zero on every entry to RUN.
    assign wd_enable = (state == RUN);
    assign wd_clear  = (state != RUN);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            watchdog_counter #(
                .limit(TIMEOUT_CYCLES)
            ) u_wd (
                .clk   (clk),
                .reset (reset),
                .clear (wd_clear),
                .enable(wd_enable),
                .expire(wd_expire)
            );
        end else begin : g_no_wd
            assign wd_expire = 1'b0;
        end
    endgenerate

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= START_ADDR;
            running <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= START_ADDR;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // A commit on the final watchdog cycle still advances pc.
                    if (instr_commit && !halt_instr) begin
                        pc <= branch ? branch_address : pc + PC_W'(1);
                    end
                    if (halt_commit) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (wd_expire) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                HALTED: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= START_ADDR;
                        running <= 1'b1;
                        done    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_SEQ_BRANCH_STATS_EN
    logic [STATS_W-1:0] taken_q;

    // Saturating count of committed taken branches; cleared whenever a run starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_q <= '0;
        end else if (start && (state != RUN)) begin
            taken_q <= '0;
        end else if (instr_commit && branch && !halt_instr && (taken_q != {STATS_W{1'b1}})) begin
            taken_q <= taken_q + STATS_W'(1);
        end
    end

    assign taken_count = taken_q;
`else
    assign taken_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: two instances (default watchdog and an
// 8-cycle watchdog) share stimulus; a reference model pushes expected results
// to per-instance queues that are popped after each clock edge.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, imem_valid, halt_instr, branch;
    logic [8:0]  branch_address;

    logic [8:0]  pc_a, pc_b;
    logic        commit_a, commit_b, running_a, running_b;
    logic        done_a, done_b, timeout_a, timeout_b;
    logic [15:0] taken_a, taken_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.PC_W(9), .START_ADDR(9'd0), .TIMEOUT_CYCLES(1023)) dut_a (
        .clk(clk), .reset(reset), .start(start), .imem_valid(imem_valid),
        .halt_instr(halt_instr), .branch(branch), .branch_address(branch_address),
        .pc(pc_a), .instr_commit(commit_a), .running(running_a), .done(done_a),
        .timeout(timeout_a), .taken_count(taken_a)
    );

    fetch_sequencer #(.PC_W(9), .START_ADDR(9'd0), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .reset(reset), .start(start), .imem_valid(imem_valid),
        .halt_instr(halt_instr), .branch(branch), .branch_address(branch_address),
        .pc(pc_b), .instr_commit(commit_b), .running(running_b), .done(done_b),
        .timeout(timeout_b), .taken_count(taken_b)
    );

    typedef struct {
        logic [8:0]  pc;
        logic        running;
        logic        done;
        logic        timeout;
        logic [15:0] taken;
        string       tag;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state per instance (0=IDLE, 1=RUN, 2=HALTED).
    int          m_state [2];
    logic [8:0]  m_pc    [2];
    int          m_cnt   [2];
    logic [15:0] m_taken [2];
    logic        m_to    [2];
    int          m_limit [2] = '{1023, 8};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input logic rst, input logic st, input logic iv,
                              input logic hi, input logic br, input logic [8:0] ba);
        if (rst) begin
            m_state[k] = 0; m_pc[k] = 9'd0; m_cnt[k] = 0; m_taken[k] = 16'd0; m_to[k] = 1'b0;
        end else begin
            case (m_state[k])
                0: if (st) begin
                    m_state[k] = 1; m_pc[k] = 9'd0; m_cnt[k] = 0; m_taken[k] = 16'd0;
                end
                1: begin
                    if (iv && !hi) begin
                        if (br) begin
                            m_pc[k] = ba;
`ifdef FETCH_SEQ_BRANCH_STATS_EN
                            if (m_taken[k] != 16'hFFFF) m_taken[k] = m_taken[k] + 16'd1;
`endif
                        end else begin
                            m_pc[k] = m_pc[k] + 9'd1;
                        end
                    end
                    if (iv && hi) begin
                        m_state[k] = 2;
                    end else if (m_limit[k] > 0 && m_cnt[k] == m_limit[k] - 1) begin
                        m_state[k] = 2; m_to[k] = 1'b1;
                    end
                    m_cnt[k]++;
                end
                2: if (st) begin
                    m_state[k] = 1; m_pc[k] = 9'd0; m_to[k] = 1'b0; m_cnt[k] = 0; m_taken[k] = 16'd0;
                end
                default: m_state[k] = 0;
            endcase
        end
    endtask

    function automatic exp_t snapshot(input int k, input string tag);
        exp_t e;
        e.pc = m_pc[k];
        e.running = (m_state[k] == 1);
        e.done = (m_state[k] == 2);
        e.timeout = m_to[k];
        e.taken = m_taken[k];
        e.tag = tag;
        return e;
    endfunction

    // One clock of stimulus: drive, check the combinational commit, push model
    // expectations, then pop and compare registered outputs after the edge.
    task automatic step(input logic rst, input logic st, input logic iv, input logic hi,
                        input logic br, input logic [8:0] ba, input string tag);
        exp_t ea, eb;
        @(negedge clk);
        reset = rst; start = st; imem_valid = iv; halt_instr = hi; branch = br; branch_address = ba;
        #1;
        check({tag, ".a.commit"}, {31'd0, commit_a}, {31'd0, (m_state[0] == 1) && iv});
        check({tag, ".b.commit"}, {31'd0, commit_b}, {31'd0, (m_state[1] == 1) && iv});
        model_step(0, rst, st, iv, hi, br, ba);
        model_step(1, rst, st, iv, hi, br, ba);
        q_a.push_back(snapshot(0, tag));
        q_b.push_back(snapshot(1, tag));
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check({ea.tag, ".a.pc"},      {23'd0, pc_a},      {23'd0, ea.pc});
        check({ea.tag, ".a.running"}, {31'd0, running_a}, {31'd0, ea.running});
        check({ea.tag, ".a.done"},    {31'd0, done_a},    {31'd0, ea.done});
        check({ea.tag, ".a.timeout"}, {31'd0, timeout_a}, {31'd0, ea.timeout});
        check({ea.tag, ".a.taken"},   {16'd0, taken_a},   {16'd0, ea.taken});
        check({eb.tag, ".b.pc"},      {23'd0, pc_b},      {23'd0, eb.pc});
        check({eb.tag, ".b.running"}, {31'd0, running_b}, {31'd0, eb.running});
        check({eb.tag, ".b.done"},    {31'd0, done_b},    {31'd0, eb.done});
        check({eb.tag, ".b.timeout"}, {31'd0, timeout_b}, {31'd0, eb.timeout});
        check({eb.tag, ".b.taken"},   {16'd0, taken_b},   {16'd0, eb.taken});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; imem_valid = 1'b0; halt_instr = 1'b0;
        branch = 1'b0; branch_address = 9'd0;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_pc[k] = 9'd0; m_cnt[k] = 0; m_taken[k] = 16'd0; m_to[k] = 1'b0;
        end

        // Reset for two cycles.
        step(1, 0, 0, 0, 0, 9'd0, "rst0");
        step(1, 0, 0, 0, 0, 9'd0, "rst1");
        check("reset.pc_literal", {23'd0, pc_a}, 32'd0);
        check("reset.flags_literal", {28'd0, running_a, done_a, timeout_a, commit_a}, 32'd0);

        // Start, then sequential fetch with a branch at pc=3.
        step(0, 1, 0, 0, 0, 9'd0, "start1");
        check("start.running_literal", {31'd0, running_a}, 32'd1);
        step(0, 0, 1, 0, 0, 9'd0, "seq1");
        step(0, 0, 1, 0, 0, 9'd0, "seq2");
        step(0, 0, 1, 0, 0, 9'd0, "seq3");
        check("seq.pc3_literal", {23'd0, pc_a}, 32'd3);
        step(0, 0, 1, 0, 1, 9'h040, "br40");
        check("branch.pc_literal", {23'd0, pc_a}, 32'h040);
        step(0, 0, 1, 0, 0, 9'd0, "seq41");
        step(0, 0, 1, 0, 0, 9'd0, "seq42");

        // PC wrap, then stall with imem_valid low.
        step(0, 0, 1, 0, 1, 9'h1FF, "br1ff");
        step(0, 0, 1, 0, 0, 9'd0, "wrap");
        check("wrap.pc_literal", {23'd0, pc_a}, 32'd0);
        step(0, 0, 0, 0, 1, 9'h0AA, "stall1");
        step(0, 0, 0, 1, 0, 9'd0, "stall2");
        step(0, 0, 0, 0, 0, 9'd0, "stall3");
        check("stall.pc_literal", {23'd0, pc_a}, 32'd0);

        // Restart both instances (a: reset, then start) and run to pc=7.
        step(1, 0, 0, 0, 0, 9'd0, "rst2");
        step(0, 1, 0, 0, 0, 9'd0, "start2");
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 9'd0, "run7");
        // HALT beats branch; on b it also coincides with watchdog expiry.
        step(0, 0, 1, 1, 1, 9'h055, "halt");
        check("halt.pc_literal", {23'd0, pc_a}, 32'd7);
        check("halt.done_literal", {31'd0, done_a}, 32'd1);
        check("halt.b_timeout_literal", {31'd0, timeout_b}, 32'd0);
        step(0, 0, 1, 0, 0, 9'd0, "halted_hold");
        step(0, 1, 0, 0, 0, 9'd0, "restart");
        check("restart.done_literal", {31'd0, done_a}, 32'd0);

        // Watchdog on b: exactly 8 RUN cycles, including one stalled cycle.
        step(0, 0, 0, 0, 0, 9'd0, "wd_stall");
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 9'd0, "wd_run");
        check("wd.b_running_literal", {31'd0, running_b}, 32'd1);
        step(0, 0, 1, 0, 0, 9'd0, "wd_last");
        check("wd.b_timeout_literal", {30'd0, done_b, timeout_b}, 32'd3);

        // Start restarts b from timeout; a is in RUN and ignores it.
        step(0, 1, 1, 0, 0, 9'd0, "start_in_run");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 9'd0, "run12");
        check("run.pc12_literal", {23'd0, pc_a}, 32'd12);

        // Reset mid-RUN returns to IDLE at that edge, no commit recorded.
        step(1, 0, 1, 0, 1, 9'h123, "rst_mid");
        check("rst_mid.pc_literal", {23'd0, pc_a}, 32'd0);
        check("rst_mid.flags_literal", {29'd0, running_a, done_a, timeout_a}, 32'd0);
        step(0, 0, 1, 0, 0, 9'd0, "idle_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
